// File: rtl/seq_cla_sub.sv
// Sequential subtractor: computes a - b - bin one SLICE-bit carry-look-ahead
// slice per clock, LSB first, and publishes diff/bout/ovf with a done pulse.
module seq_cla_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;         // minuend, shifted right one slice per cycle
  logic [WIDTH-1:0] b_q, b_d;         // subtrahend, shifted right one slice per cycle
  logic             sa_q, sa_d;       // latched sign of a, needed for overflow
  logic             sb_q, sb_d;       // latched sign of b, needed for overflow
  logic [WIDTH-1:0] acc_q, acc_d;     // partial difference, filled from the top
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] sl_g;
  logic [SLICE-1:0] sl_p;
  logic [SLICE:0]   sl_c;
  logic [SLICE-1:0] sl_sum;

  // Carry-look-ahead slice on a + ~b + carry: every carry is a flat sum of
  // generate/propagate products rather than a ripple chain.
  always_comb begin
    logic cy;
    logic run;
    sl_g    = a_q[SLICE-1:0] & ~b_q[SLICE-1:0];
    sl_p    = a_q[SLICE-1:0] ^ ~b_q[SLICE-1:0];
    sl_c    = '0;
    sl_c[0] = carry_q;
    for (int i = 0; i < int'(SLICE); i++) begin
      cy  = sl_g[i];
      run = sl_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cy  = cy | (run & sl_g[j]);
        run = run & sl_p[j];
      end
      cy          = cy | (run & carry_q);
      sl_c[i + 1] = cy;
    end
    sl_sum = sl_p ^ sl_c[SLICE-1:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          a_d     = a;
          b_d     = b;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          carry_d = ~bin;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        carry_d = sl_c[SLICE];
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = (acc_q >> SLICE) | (WIDTH'(sl_sum) << (WIDTH - SLICE));
        k_d     = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          state_d = DONE;
          diff_d  = acc_d;
          bout_d  = ~sl_c[SLICE];
          ovf_d   = (sa_q != sb_q) && (acc_d[WIDTH-1] != sa_q);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_cla_sub.sv
// Directed bench for seq_cla_sub at default parameters (WIDTH=16, SLICE=4).
module tb_seq_cla_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_cla_sub #(.WIDTH(16), .SLICE(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  // Hand-computed vectors: a, b, bin -> diff, bout, ovf
  localparam int NV = 7;
  localparam logic [15:0] VA   [NV] = '{16'd5000, 16'd1301,  16'd0,     16'h7FFF, 16'h8000, 16'd100, 16'h8000};
  localparam logic [15:0] VB   [NV] = '{16'd990,  16'd13332, 16'd0,     16'hFFFF, 16'h0001, 16'd50,  16'h7FFF};
  localparam logic        VBI  [NV] = '{1'b0,     1'b0,      1'b1,      1'b0,     1'b0,     1'b1,    1'b0};
  localparam logic [15:0] VD   [NV] = '{16'd4010, 16'd53505, 16'd65535, 16'h8000, 16'h7FFF, 16'd49,  16'h0001};
  localparam logic        VBO  [NV] = '{1'b0,     1'b1,      1'b1,      1'b1,     1'b0,     1'b0,    1'b0};
  localparam logic        VOV  [NV] = '{1'b0,     1'b0,      1'b0,      1'b1,     1'b1,     1'b0,    1'b1};

  // Issue one operation from IDLE (called at posedge+1); collects results, no checking.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_bin,
                        output int lat, output logic [15:0] d, output logic bo,
                        output logic ov, output logic hold_ok);
    logic [15:0] prev;
    prev    = diff;
    a       = op_a;
    b       = op_b;
    bin     = op_bin;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    lat     = 0;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1 || diff !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    d  = diff;
    bo = bout;
    ov = ovf;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h0001; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (diff !== 16'd0) begin errors++; $display("FAIL reset_diff: got %0d expected 0", diff); end
    checks++; if (bout !== 1'b0)  begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    int lat; logic [15:0] d; logic bo, ov, hold_ok;
    for (int i = 0; i < NV; i++) begin
      run_op(VA[i], VB[i], VBI[i], lat, d, bo, ov, hold_ok);
      checks++; if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (d !== VD[i]) begin errors++; $display("FAIL vec%0d_diff: got %h expected %h", i, d, VD[i]); end
      checks++; if (bo !== VBO[i]) begin errors++; $display("FAIL vec%0d_bout: got %b expected %b", i, bo, VBO[i]); end
      checks++; if (ov !== VOV[i]) begin errors++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ov, VOV[i]); end
      checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL vec%0d_calc_hold: got %b expected 1", i, hold_ok); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_in_done: got %b expected 0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL vec%0d_done_pulse: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_input_change;
    int lat;
    a = 16'd5000; b = 16'd990; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); start = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (lat !== 4) begin errors++; $display("FAIL chg_latency: got %0d expected 4", lat); end
    checks++; if (diff !== 16'd4010) begin errors++; $display("FAIL chg_diff: got %0d expected 4010", diff); end
    checks++; if (bout !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL chg_flags: got bout=%b ovf=%b expected 0 0", bout, ovf);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL chg_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [15:0] exp_d;
    logic        exp_bo;
    a = 16'd5000; b = 16'd990; bin = 1'b0; start = 1'b1;
    for (int op = 0; op < 4; op++) begin
      exp_d  = (op % 2 == 0) ? 16'd4010 : 16'd53505;
      exp_bo = (op % 2 == 0) ? 1'b0 : 1'b1;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (done !== 1'b1 && cyc < 20);
      checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b%0d_period: got %0d expected 5", op, cyc); end
      checks++; if (diff !== exp_d) begin errors++; $display("FAIL b2b%0d_diff: got %0d expected %0d", op, diff, exp_d); end
      checks++; if (bout !== exp_bo) begin errors++; $display("FAIL b2b%0d_bout: got %b expected %b", op, bout, exp_bo); end
      if (op % 2 == 0) begin a = 16'd1301; b = 16'd13332; end
      else begin a = 16'd5000; b = 16'd990; end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] d; logic bo, ov, hold_ok;
    logic saw_done;
    a = 16'd32700; b = 16'd67; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b expected 0", done); end
    checks++; if (diff !== 16'd0) begin errors++; $display("FAIL rmid_diff: got %0d expected 0", diff); end
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got %b expected 0", saw_done); end
    run_op(16'd32700, 16'd67, 1'b0, lat, d, bo, ov, hold_ok);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rmid_restart_latency: got %0d expected 4", lat); end
    checks++; if (d !== 16'd32633) begin errors++; $display("FAIL rmid_restart_diff: got %0d expected 32633", d); end
    checks++; if (bo !== 1'b0 || ov !== 1'b0) begin
      errors++; $display("FAIL rmid_restart_flags: got bout=%b ovf=%b expected 0 0", bo, ov);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_vectors();
    test_input_change();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_cla_sub.md
SEQ_CLA_SUB -- requirements
Module: seq_cla_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle by the internal carry-look-ahead slice; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a subtraction; sampled only when busy=0.
REQ-006 SHALL have port a  input  WIDTH  minuend; sampled at the accepting edge only.
REQ-007 SHALL have port b  input  WIDTH  subtrahend; sampled at the accepting edge only.
REQ-008 SHALL have port bin  input  1  borrow-in; sampled at the accepting edge only.
REQ-009 SHALL have port diff  output  WIDTH  registered result a-b-bin modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  registered borrow-out; 1 when unsigned a < b+bin.
REQ-011 SHALL have port ovf  output  1  registered two's-complement overflow of the signed subtraction.
REQ-012 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking a new valid diff/bout/ovf.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; N = WIDTH/SLICE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch a, b, and ~bin as initial carry, clear the slice index, and enter CALC.
REQ-016 In IDLE or DONE, start=0 at an edge SHALL enter or stay in IDLE.
REQ-017 In CALC, each edge SHALL compute slice k (LSB first) as a_k + ~b_k + carry with carry-look-ahead logic, store the SLICE sum bits, update carry, and increment k.
REQ-018 CALC SHALL last exactly N edges (N=4 at defaults); the Nth edge SHALL enter DONE.
REQ-019 At the edge entering DONE, diff SHALL load the full assembled difference, bout SHALL load ~final carry, and ovf SHALL load (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
REQ-020 done SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle.
REQ-021 busy SHALL be 1 exactly in CALC.
REQ-022 Latency: start accepted at edge E0 gives done=1 in the cycle after edge E(N), i.e. 4 cycles at defaults.
REQ-023 diff, bout and ovf SHALL hold their last values outside the edge entering DONE; partial results SHALL never appear on diff.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT disturb the operation or the latched operands.
REQ-025 start=1 during the DONE cycle SHALL be accepted; back-to-back operations SHALL sustain one result per N+1 cycles.
REQ-026 Input changes on a, b, bin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and clear diff, bout, ovf, busy, done, the slice index, carry, and latched operands to 0, overriding start.
REQ-028 rst asserted mid-CALC SHALL abort the operation with no done pulse; diff SHALL read 0 afterwards.
REQ-029 The first start after rst deasserts SHALL be accepted normally at the next edge.

Verification
REQ-030 a=5000, b=990, bin=0, start pulse -> after 4 cycles done=1, diff=4010, bout=0, ovf=0.
REQ-031 a=1301, b=13332, bin=0 -> diff=53505 (0xD101), bout=1, ovf=0; with a=0, b=0, bin=1 -> diff=65535, bout=1, ovf=0.
REQ-032 a=0x7FFF, b=0xFFFF, bin=0 -> diff=0x8000, bout=1, ovf=1; a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-033 Start held high continuously with the operand sets of REQ-030 and REQ-031 alternating each accept -> done every 5 cycles, correct diffs, and start during busy ignored.
REQ-034 rst pulsed on the 2nd CALC cycle of a=32700, b=67 -> no done, busy=0, and diff=0 next cycle; a restarted op gives diff=32633, bout=0.
REQ-035 Changing a, b and bin every cycle during CALC -> result equals the values sampled at acceptance.
